led_serial_receiver: RTL and testbench
======================================

Name: led_serial_receiver

Overview:
- Receiving end of the LED serial link: deserialises the one-bit data stream and active-low latch strobe driven by the LED shift transmitter.
- Presents each completed frame as a parallel word with a one-cycle valid pulse.
- Sits on the display/sink side or in loopback test harnesses. Detects short and long frames.

Parameters:
- WIDTH, 16, frame length in bits; must be a multiple of 8, minimum 8.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data bit, one bit per clk cycle.
- latch  input  1  frame strobe; 1 = shifting, 0 for one cycle = last bit of frame.
- data_out  output  WIDTH  last good frame, parallel.
- valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse on a frame with the wrong bit count.
- synced  output  1  high once the first frame boundary has been seen.

Behaviour:
- Reset (async, rst_n=0): data_out=0, valid=0, frame_err=0, synced=0, bit counter=0, overrun flag=0, state=SYNC.
- Frame format: WIDTH consecutive cycles. latch=1 on the first WIDTH-1 cycles and latch=0 on the last cycle. serial_in is sampled on every cycle, including the latch=0 cycle.
- Bit order (byte-wise MSB-first, low byte first):
  - Serial bits 0..7 -> data_out[7:0], MSB first.
  - Serial bits 8..15 -> data_out[15:8], MSB first.
  - Each further byte follows the same pattern.
- SYNC state:
  - Bits are ignored while latch=1.
  - Sampling latch=0 -> go to RUN, set synced=1, clear the counter.
  - No valid or frame_err is produced from this partial frame.
- RUN, latch=1:
  - Store the bit at the current index and increment the counter.
  - If the counter is already WIDTH-1, set the overrun flag, hold the counter and discard the bit.
- RUN, latch=0:
  - Store the bit as index WIDTH-1 candidate.
  - If counter==WIDTH-1 and no overrun: load the assembled word into data_out; valid=1 in the following cycle.
  - Otherwise: frame_err=1 in the following cycle; data_out is held.
  - In both cases clear the counter and the overrun flag and stay in RUN.
- Latency: data_out and valid change at the clock edge that samples latch=0, i.e. visible one cycle after the last bit is presented.
- valid and frame_err are mutually exclusive and never high for two consecutive cycles unless two consecutive latch=0 samples occur.
- Consecutive latch=0 cycles in RUN: each one is a frame of length 1 -> frame_err pulse, provided WIDTH>1.
- Back-to-back frames with no gap are supported; there is no idle requirement between frames.
- Reset asserted mid-frame: immediate return to SYNC. The partial frame is lost, and data_out returns to 0.
- Internal assembly buffer: WIDTH bits, separate from data_out, so a bad frame never corrupts data_out.

Optional Feature:
- LED_RX_ERRCNT_EN defined:
  - Adds output port err_count, 8 bits: a saturating count of frame_err pulses since reset.
  - Holds at 255; reset value 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package led_pkg:
  - LED_WIDTH default constant (16).
  - State typedef {SYNC, RUN}.
  - Function mapping serial index to parallel bit position (byte-wise MSB-first).
  - The transmitter reuses the same package.
- One sub-module, led_rx_deser: assembly buffer + bit counter + overrun flag. The top holds the FSM, output registers and optional counter.

Test Plan:
- Reset, then one latch=0 cycle, then 16-bit frame 0x5A then 0xA5 serial (0,1,0,1,1,0,1,0,1,0,1,0,0,1,0,1), latch=0 on the last bit -> synced=1, data_out=16'hA55A, valid pulses exactly once one cycle later, frame_err=0.
- Three back-to-back frames 0x1234, 0xFFFF, 0x0000 with no gaps -> three valid pulses 16 cycles apart; data_out sequence 1234, FFFF, 0000.
- After a good 0xBEEF, send a 15-bit frame (latch low on the 15th bit) -> frame_err pulse, valid=0, data_out stays 0xBEEF.
- 18-bit frame (latch low on the 18th bit) -> frame_err pulse, data_out unchanged; next correct frame 0x00C3 -> valid, data_out=0x00C3.
- rst_n pulsed low at bit 8 of a frame -> outputs 0 immediately (asynchronously), synced=0; the remainder of the frame plus its latch produces no valid; the next full frame is received correctly.
- With LED_RX_ERRCNT_EN: 300 short frames -> err_count saturates at 255; a reset clears it to 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED serial link (transmitter and receiver).
package led_pkg;

   localparam int LED_WIDTH = 16;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } led_state_e;

   // Serial index -> parallel bit: bytes fill low byte first, each byte MSB first.
   function automatic int led_bit_pos(input int idx);
      return (idx & ~7) | (7 - (idx & 7));
   endfunction

endpackage

// File: rtl/led_rx_deser.sv
// Assembly buffer, bit counter and overrun flag for the LED serial receiver.
module led_rx_deser
   import led_pkg::*;
#(
   parameter int WIDTH = LED_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             serial_in,
   input  logic             latch,
   output logic [WIDTH-1:0] word,
   output logic             frame_ok
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_POS = CW'(led_bit_pos(WIDTH - 1));

   logic [WIDTH-1:0] asm_q, asm_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovr_q, ovr_d;
   logic [CW-1:0]    pos;

   always_comb begin
      asm_d = asm_q;
      cnt_d = cnt_q;
      ovr_d = ovr_q;
      pos   = CW'(led_bit_pos(int'(cnt_q)));
      if (!latch) begin
         cnt_d = '0;
         ovr_d = 1'b0;
      end else if (run) begin
         // Too many bits: remember it, but keep the buffer intact.
         if (cnt_q == LAST) begin
            ovr_d = 1'b1;
         end else begin
            asm_d[pos] = serial_in;
            cnt_d      = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         asm_q <= asm_d;
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
      end
   end

   // The final bit arrives with the strobe, so it is merged combinationally.
   always_comb begin
      word           = asm_q;
      word[LAST_POS] = serial_in;
   end

   assign frame_ok = (cnt_q == LAST) && !ovr_q;

endmodule

// File: rtl/led_serial_receiver.sv
// LED serial link receiver: frame sync FSM and parallel output registers.
// Optional saturating error counter enabled by defining LED_RX_ERRCNT_EN.
//
// state | meaning
// SYNC  | waiting for the first latch strobe; bits ignored
// RUN   | aligned to frame boundaries; every strobe closes a frame
module led_serial_receiver
   import led_pkg::*;
#(
   parameter int WIDTH = LED_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   input  logic             latch,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             frame_err,
`ifdef LED_RX_ERRCNT_EN
   output logic [7:0]       err_count,
`endif
   output logic             synced
);

   led_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             synced_q, synced_d;
   logic [WIDTH-1:0] word;
   logic             frame_ok;

   led_rx_deser #(.WIDTH(WIDTH)) u_deser (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state_q == RUN),
      .serial_in (serial_in),
      .latch     (latch),
      .word      (word),
      .frame_ok  (frame_ok)
   );

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      synced_d = synced_q;
      case (state_q)
         SYNC: begin
            if (!latch) begin
               state_d  = RUN;
               synced_d = 1'b1;
            end
         end
         RUN: begin
            if (!latch) begin
               if (frame_ok) begin
                  data_d  = word;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SYNC;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         synced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         synced_q <= synced_d;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = err_q;
   assign synced    = synced_q;

`ifdef LED_RX_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;

   // Counts alongside the frame_err pulse and sticks at full scale.
   always_comb begin
      errcnt_d = errcnt_q;
      if (err_d && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) errcnt_q <= 8'd0;
      else        errcnt_q <= errcnt_d;
   end

   assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_led_serial_receiver.sv
// Directed bench for led_serial_receiver with a scoreboard of expected frame results.
module tb_led_serial_receiver;
   import led_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        serial_in;
   logic        latch;
   logic [15:0] data_out;
   logic        valid;
   logic        frame_err;
   logic        synced;
`ifdef LED_RX_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      bit          is_err;
      logic [15:0] data;
      time         t;
   } exp_t;

   exp_t sb[$];

   led_serial_receiver #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .serial_in (serial_in),
      .latch     (latch),
      .data_out  (data_out),
      .valid     (valid),
      .frame_err (frame_err),
`ifdef LED_RX_ERRCNT_EN
      .err_count (err_count),
`endif
      .synced    (synced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Inputs change at posedge+1; the DUT samples them at the next posedge.
   task automatic drive(input logic b, input logic l);
      serial_in = b;
      latch     = l;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_last(input logic b, input bit is_err, input logic [15:0] d);
      exp_t e;
      serial_in = b;
      latch     = 1'b0;
      e.is_err  = is_err;
      e.data    = d;
      e.t       = $time;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic ser_bit(input logic [15:0] w, input int i);
      return w[(i / 8) * 8 + 7 - (i % 8)];
   endfunction

   task automatic send_frame(input logic [15:0] w);
      for (int i = 0; i < 15; i++) drive(ser_bit(w, i), 1'b1);
      drive_last(ser_bit(w, 15), 1'b0, w);
   endtask

   task automatic send_bad(input int n);
      for (int i = 0; i < n - 1; i++) drive(1'($urandom_range(0, 1)), 1'b1);
      drive_last(1'($urandom_range(0, 1)), 1'b1, 16'h0);
   endtask

   // Scoreboard: every output pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (valid || frame_err)) begin
         chk("valid_err_exclusive", 32'(valid & frame_err), 32'd0);
         chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pulse_kind_is_err", 32'(frame_err), 32'(e.is_err));
            chk("pulse_latency", 32'($time - e.t), 32'd14);
            if (!e.is_err) chk("frame_data", 32'(data_out), 32'(e.data));
         end
      end
   end

   initial begin
      logic [15:0] seq;
      rst_n     = 1'b0;
      serial_in = 1'b0;
      latch     = 1'b1;
      #12;
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_synced", 32'(synced), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Partial frame boundary: sync only, no pulses.
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      chk("sync_synced", 32'(synced), 32'd1);
      chk("sync_no_valid", 32'(valid), 32'd0);
      chk("sync_no_err", 32'(frame_err), 32'd0);

      // Explicit bit pattern 0x5A then 0xA5.
      seq = 16'b0101_1010_1010_0101;
      for (int i = 0; i < 15; i++) drive(seq[15 - i], 1'b1);
      drive_last(seq[0], 1'b0, 16'hA55A);
      chk("first_data", 32'(data_out), 32'hA55A);
      chk("first_valid", 32'(valid), 32'd1);
      chk("first_no_err", 32'(frame_err), 32'd0);

      // Back-to-back frames, no gaps.
      send_frame(16'h1234);
      send_frame(16'hFFFF);
      send_frame(16'h0000);
      chk("b2b_last_data", 32'(data_out), 32'h0000);

      // Short frame after a good one.
      send_frame(16'hBEEF);
      send_bad(15);
      chk("short_err", 32'(frame_err), 32'd1);
      chk("short_no_valid", 32'(valid), 32'd0);
      chk("short_hold", 32'(data_out), 32'hBEEF);

      // Long frame, then recovery.
      send_bad(18);
      chk("long_err", 32'(frame_err), 32'd1);
      chk("long_hold", 32'(data_out), 32'hBEEF);
      send_frame(16'h00C3);
      chk("recover_data", 32'(data_out), 32'h00C3);
      chk("recover_valid", 32'(valid), 32'd1);

      // Consecutive strobes: each is a one-bit frame.
      send_bad(1);
      send_bad(1);
      chk("single_hold", 32'(data_out), 32'h00C3);

      // Reset mid-frame.
      for (int i = 0; i < 8; i++) drive(ser_bit(16'h7E81, i), 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_data_out", 32'(data_out), 32'd0);
      chk("midrst_synced", 32'(synced), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 8; i < 15; i++) drive(ser_bit(16'h7E81, i), 1'b1);
      drive(ser_bit(16'h7E81, 15), 1'b0);
      chk("resync_synced", 32'(synced), 32'd1);
      chk("resync_no_valid", 32'(valid), 32'd0);
      send_frame(16'h3C96);
      chk("after_rst_data", 32'(data_out), 32'h3C96);

`ifdef LED_RX_ERRCNT_EN
      chk("errcnt_zero_after_rst", 32'(err_count), 32'd0);
      repeat (300) send_bad(2);
      chk("errcnt_saturated", 32'(err_count), 32'd255);
      #3;
      rst_n = 1'b0;
      #1;
      chk("errcnt_cleared", 32'(err_count), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`endif

      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
